// File: rtl/sprite_blitter.sv
// Pipelined sprite fetch: frame-synchronous position update, integer upscale, ROM fetch, transparency.
// Optional SPRITE_HFLIP_EN enables horizontal mirroring latched with each position request.
module sprite_blitter #(
  parameter int SPRITE_W        = 60,
  parameter int SPRITE_H        = 60,
  parameter int SCALE_LOG2      = 0,
  parameter int ADDR_W          = 12,
  parameter int IDX_W           = 4,
  parameter int TRANSPARENT_IDX = 0
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              pos_valid,
  output logic              pos_ready,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic              sprite_hit,
  output logic [IDX_W-1:0]  sprite_idx,
  input  logic              hflip
);

  localparam logic [10:0]      SPAN_X = 11'(SPRITE_W << SCALE_LOG2);
  localparam logic [10:0]      SPAN_Y = 11'(SPRITE_H << SCALE_LOG2);
  localparam logic [IDX_W-1:0] TRANSP = IDX_W'(TRANSPARENT_IDX);

  logic [9:0]        act_x_q, act_y_q, pend_x_q, pend_y_q;
  logic              pend_full_q;
  logic              s0_valid_q, s1_valid_q, s2_valid_q;
  logic [9:0]        s0_rx_q, s0_ry_q;
  logic [ADDR_W-1:0] rom_address_q;
  logic              sprite_hit_q;
  logic [IDX_W-1:0]  sprite_idx_q;

  logic [10:0]       rx_d, ry_d;
  logic              in_range_d;
  logic [9:0]        tx_d, ty_d;
  logic [ADDR_W-1:0] addr_d;
  logic              hit_d;

`ifdef SPRITE_HFLIP_EN
  logic act_hflip_q, pend_hflip_q, s0_hflip_q;
`else
  logic unused_hflip;
  assign unused_hflip = hflip;
`endif

  // Bit 10 of the 11-bit difference is the borrow: pixel left of / above the sprite.
  always_comb begin
    rx_d       = {1'b0, DrawX} - {1'b0, act_x_q};
    ry_d       = {1'b0, DrawY} - {1'b0, act_y_q};
    in_range_d = ~rx_d[10] & ~ry_d[10] & (rx_d < SPAN_X) & (ry_d < SPAN_Y);
  end

  always_comb begin
    tx_d = s0_rx_q >> SCALE_LOG2;
    ty_d = s0_ry_q >> SCALE_LOG2;
`ifdef SPRITE_HFLIP_EN
    if (s0_hflip_q) tx_d = 10'(SPRITE_W - 1) - (s0_rx_q >> SCALE_LOG2);
`endif
    addr_d = s0_valid_q ? ADDR_W'(int'(ty_d) * SPRITE_W + int'(tx_d)) : '0;
    hit_d  = s2_valid_q & (rom_q != TRANSP);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      act_x_q       <= '0;
      act_y_q       <= '0;
      pend_x_q      <= '0;
      pend_y_q      <= '0;
      pend_full_q   <= 1'b0;
      s0_valid_q    <= 1'b0;
      s0_rx_q       <= '0;
      s0_ry_q       <= '0;
      s1_valid_q    <= 1'b0;
      s2_valid_q    <= 1'b0;
      rom_address_q <= '0;
      sprite_hit_q  <= 1'b0;
      sprite_idx_q  <= '0;
`ifdef SPRITE_HFLIP_EN
      act_hflip_q   <= 1'b0;
      pend_hflip_q  <= 1'b0;
      s0_hflip_q    <= 1'b0;
`endif
    end else begin
      // Apply and accept are exclusive: acceptance needs an empty pending slot.
      if (frame_start && pend_full_q) begin
        act_x_q     <= pend_x_q;
        act_y_q     <= pend_y_q;
        pend_full_q <= 1'b0;
`ifdef SPRITE_HFLIP_EN
        act_hflip_q <= pend_hflip_q;
`endif
      end else if (pos_valid && !pend_full_q) begin
        pend_x_q     <= pos_x;
        pend_y_q     <= pos_y;
        pend_full_q  <= 1'b1;
`ifdef SPRITE_HFLIP_EN
        pend_hflip_q <= hflip;
`endif
      end

      s0_valid_q    <= in_range_d & blank;
      s0_rx_q       <= rx_d[9:0];
      s0_ry_q       <= ry_d[9:0];
`ifdef SPRITE_HFLIP_EN
      s0_hflip_q    <= act_hflip_q;
`endif
      s1_valid_q    <= s0_valid_q;
      rom_address_q <= addr_d;
      s2_valid_q    <= s1_valid_q;
      sprite_hit_q  <= hit_d;
      sprite_idx_q  <= hit_d ? rom_q : '0;
    end
  end

  assign pos_ready   = ~pend_full_q;
  assign rom_address = rom_address_q;
  assign sprite_hit  = sprite_hit_q;
  assign sprite_idx  = sprite_idx_q;

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Parametrised, pipelined sprite fetch engine that places one ROM-backed sprite at a runtime-programmable screen position with integer upscaling and transparency. It sits between the VGA timing generator and the pixel mux/palette stage: it drives the sprite ROM address, reads back the colour index and reports per pixel whether the sprite covers it. Position updates use a valid/ready handshake and take effect only at a frame boundary, so a sprite never tears mid-frame.

## Interface
- SPRITE_W, 60: sprite width in source texels
- SPRITE_H, 60: sprite height in source texels
- SCALE_LOG2, 0: upscale factor = 2^SCALE_LOG2; legal 0..3
- ADDR_W, 12: ROM address width; must hold SPRITE_W*SPRITE_H-1
- IDX_W, 4: palette index width
- TRANSPARENT_IDX, 0: index treated as "no pixel"

- vga_clk  in  1  pixel clock; all logic on posedge
- reset  in  1  synchronous, active-high
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- blank  in  1  1 = visible region (draw allowed)
- frame_start  in  1  one-cycle pulse at first pixel of a frame
- pos_x  in  10  requested sprite left column
- pos_y  in  10  requested sprite top row
- pos_valid  in  1  position request valid
- pos_ready  out  1  block can accept a position
- rom_address  out  ADDR_W  registered ROM address
- rom_q  in  IDX_W  ROM data, synchronous, 1-cycle read latency
- sprite_hit  out  1  sprite covers this pixel with an opaque texel
- sprite_idx  out  IDX_W  palette index; 0 when sprite_hit = 0
- hflip  in  1  mirror horizontally (only with SPRITE_HFLIP_EN)

## Operation
- Registers: active position (act_x, act_y), pending position (pend_x, pend_y, pend_full).
- Handshake: pos_ready = ~pend_full. Transfer when pos_valid & pos_ready: pend_* ← pos_*, pend_full ← 1.
- On frame_start with pend_full = 1: act_* ← pend_*, pend_full ← 0. Transfer in the same cycle as frame_start is stored as pending and applied at the next frame_start.
- Stage 0 (edge k): rx = DrawX − act_x, ry = DrawY − act_y, 11-bit; in_range = no borrow on either, rx < SPRITE_W<<SCALE_LOG2, ry < SPRITE_H<<SCALE_LOG2; registers in_range & blank.
- Stage 1 (edge k+1): tx = rx>>SCALE_LOG2, ty = ry>>SCALE_LOG2; rom_address ← ty*SPRITE_W + tx (constant multiply), or 0 when not in range. Valid bit propagated.
- Stage 2 (edge k+2): ROM returns rom_q; valid bit propagated.
- Stage 3 (edge k+3): sprite_hit ← valid & (rom_q ≠ TRANSPARENT_IDX); sprite_idx ← sprite_hit ? rom_q : 0.
- Clipping: sprite extending past column 639 / row 479 is clipped by blank; no wrap to opposite edge.

## Timing
- Reset: act_x = act_y = 0, pend_full = 0, pos_ready = 1 in the cycle after reset deasserts, rom_address = 0, sprite_hit = 0, sprite_idx = 0, all pipeline valid bits 0.
- Reset mid-frame: pipeline flushed; outputs 0 on the next edge; pending request discarded.
- Latency: DrawX/DrawY/blank sampled at edge k → sprite_hit/sprite_idx valid after edge k+3; fixed, no stalls, one pixel per cycle.
- Position change is visible on the first pixel whose stage 0 sample occurs after the frame_start edge that loaded act_*.
- pos_ready drops the cycle after acceptance, rises the cycle after the applying frame_start.

## Configuration
- SPRITE_HFLIP_EN defined: hflip sampled with the position request (stored with pend_*, applied at frame_start); when active, tx = SPRITE_W−1−(rx>>SCALE_LOG2).
- Undefined: hflip port present but ignored; tx = rx>>SCALE_LOG2.

## Test plan
- Reset then act at (0,0), SCALE_LOG2=0, ROM idx = address[3:0]: pixel (5,2) → rom_address 125, sprite_hit=1, sprite_idx=13 after 3 edges.
- Request (100,50) mid-frame → pos_ready=0 next cycle, old position still drawn; after frame_start, pixel (100,50) → rom_address 0, pixel (99,50) → sprite_hit=0.
- SCALE_LOG2=1, position (0,0): pixels (0,0),(1,0),(0,1),(1,1) all → address 0; pixel (119,119) → address 3599; pixel (120,0) → miss.
- Texel equal to TRANSPARENT_IDX=0 inside sprite → sprite_hit=0, sprite_idx=0; blank=0 over sprite → sprite_hit=0.
- Position (620,470): pixel (639,479) hits address 9*60+19=559; no hit at column 0 of next line.
- With SPRITE_HFLIP_EN, hflip=1, position (0,0): pixel (0,0) → address 59; without macro → address 0.
